multi_edge_detect: RTL and testbench

- Parametrised, multi-channel successor to the single-channel edge-detect FSM.
- Each of N asynchronous level inputs is synchronised, optionally debounced, and edge-classified. Each channel's mode selects rising, falling or both edges.
- Emits a registered one-cycle tick per detected edge, plus per-channel sticky pending flags for a polling controller.
- Sits between raw button/status pins and control FSMs.

---
 rtl/multi_edge_detect.sv | 129 ++++++++++++
 tb/tb_multi_edge_detect.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detect.sv
// Multi-channel synchronise / debounce / edge-classify block with per-channel
// polarity masks, one-cycle edge ticks and sticky pending flags for polling.
module multi_edge_detect #(
  parameter  int N           = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int DEBOUNCE    = 0,
  localparam int CW          = (DEBOUNCE == 0) ? 1 : $clog2(DEBOUNCE + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   level,
  input  logic [2*N-1:0] mode,
  input  logic [N-1:0]   clr,
  output logic [N-1:0]   tick,
  output logic [N-1:0]   rise,
  output logic [N-1:0]   state,
  output logic [N-1:0]   pending,
  output logic           any_tick
);

  typedef enum logic {
    STABLE = 1'b0,
    FILTER = 1'b1
  } fsm_e;

  logic [N-1:0] s;
  logic [N-1:0] tick_d;
  logic         any_tick_q;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s = level;
    end else begin : g_sync
      logic [N-1:0] sync_q [SYNC_STAGES];

      // NOTE: the synchroniser is a short chain of real flops, not a RAM, so
      // resetting every stage is cheap and keeps post-reset behaviour defined.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
        end else begin
          sync_q[0] <= level;
          for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  for (genvar i = 0; i < N; i++) begin : g_ch
    fsm_e          fsm_q;
    logic [CW-1:0] cnt_q;
    logic          state_q;
    logic          tick_q;
    logic          rise_q;
    logic          pend_q;
    logic          commit;
    logic          qual;

    // NOTE: default first so every path assigns commit and no latch is inferred.
    always_comb begin
      commit = 1'b0;
      if (s[i] != state_q) begin
        if (fsm_q == STABLE) commit = (DEBOUNCE == 0);
        else                 commit = (cnt_q == CW'(DEBOUNCE));
      end
    end

    // mode bit 0 enables rising edges, bit 1 enables falling edges.
    assign qual      = commit & (s[i] ? mode[2*i] : mode[2*i+1]);
    assign tick_d[i] = qual;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        fsm_q   <= STABLE;
        cnt_q   <= '0;
        state_q <= 1'b0;
        tick_q  <= 1'b0;
        rise_q  <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        tick_q <= qual;
        if (qual) rise_q <= s[i];
        pend_q <= qual | (pend_q & ~clr[i]);

        if (commit) begin
          state_q <= s[i];
          fsm_q   <= STABLE;
          cnt_q   <= '0;
        end else begin
          case (fsm_q)
            STABLE: begin
              if (s[i] != state_q) begin
                fsm_q <= FILTER;
                cnt_q <= CW'(1);
              end
            end
            FILTER: begin
              if (s[i] == state_q) begin
                fsm_q <= STABLE;
                cnt_q <= '0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
            default: begin
              fsm_q <= STABLE;
              cnt_q <= '0;
            end
          endcase
        end
      end
    end

    assign tick[i]    = tick_q;
    assign rise[i]    = rise_q;
    assign state[i]   = state_q;
    assign pending[i] = pend_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_tick_q <= 1'b0;
    else          any_tick_q <= |tick_d;
  end

  assign any_tick = any_tick_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect: three configurations share one stimulus stream
// and are compared each cycle against a consecutive-sample reference model.
module tb_multi_edge_detect;

  localparam int NC = 3;
  localparam int S_OF [NC] = '{2, 2, 0};
  localparam int D_OF [NC] = '{0, 3, 0};

  logic       clk;
  logic       reset_n;
  logic [3:0] level;
  logic [7:0] mode;
  logic [3:0] clr;

  logic [3:0] o_tick  [NC];
  logic [3:0] o_rise  [NC];
  logic [3:0] o_state [NC];
  logic [3:0] o_pend  [NC];
  logic       o_any   [NC];

  multi_edge_detect #(.N(4), .SYNC_STAGES(2), .DEBOUNCE(0)) u_a (
    .clk(clk), .reset_n(reset_n), .level(level), .mode(mode), .clr(clr),
    .tick(o_tick[0]), .rise(o_rise[0]), .state(o_state[0]),
    .pending(o_pend[0]), .any_tick(o_any[0]));

  multi_edge_detect #(.N(4), .SYNC_STAGES(2), .DEBOUNCE(3)) u_b (
    .clk(clk), .reset_n(reset_n), .level(level), .mode(mode), .clr(clr),
    .tick(o_tick[1]), .rise(o_rise[1]), .state(o_state[1]),
    .pending(o_pend[1]), .any_tick(o_any[1]));

  multi_edge_detect #(.N(4), .SYNC_STAGES(0), .DEBOUNCE(0)) u_c (
    .clk(clk), .reset_n(reset_n), .level(level), .mode(mode), .clr(clr),
    .tick(o_tick[2]), .rise(o_rise[2]), .state(o_state[2]),
    .pending(o_pend[2]), .any_tick(o_any[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: s is the level seen S edges ago; a channel commits once
  // s has disagreed with the committed level on D+1 consecutive edges.
  logic [3:0] m_hist  [NC][2];
  int         m_run   [NC][4];
  logic [3:0] m_st    [NC];
  logic [3:0] m_tick  [NC];
  logic [3:0] m_rise  [NC];
  logic [3:0] m_pend  [NC];
  logic       m_any   [NC];

  task automatic model_zero();
    for (int c = 0; c < NC; c++) begin
      m_hist[c][0] = '0; m_hist[c][1] = '0;
      for (int i = 0; i < 4; i++) m_run[c][i] = 0;
      m_st[c] = '0; m_tick[c] = '0; m_rise[c] = '0; m_pend[c] = '0; m_any[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] s;
    logic [3:0] t;
    if (!reset_n) begin
      model_zero();
      return;
    end
    for (int c = 0; c < NC; c++) begin
      s = (S_OF[c] == 0) ? level : m_hist[c][S_OF[c]-1];
      t = '0;
      for (int i = 0; i < 4; i++) begin
        if (s[i] != m_st[c][i]) begin
          m_run[c][i]++;
          if (m_run[c][i] == D_OF[c] + 1) begin
            m_run[c][i] = 0;
            m_st[c][i]  = s[i];
            t[i] = s[i] ? mode[2*i] : mode[2*i+1];
            if (t[i]) m_rise[c][i] = s[i];
          end
        end else begin
          m_run[c][i] = 0;
        end
      end
      m_pend[c] = t | (m_pend[c] & ~clr);
      m_tick[c] = t;
      m_any[c]  = |t;
      m_hist[c][1] = m_hist[c][0];
      m_hist[c][0] = level;
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      check($sformatf("cfg%0d tick", c),     o_tick[c],  m_tick[c]);
      check($sformatf("cfg%0d rise", c),     o_rise[c],  m_rise[c]);
      check($sformatf("cfg%0d state", c),    o_state[c], m_st[c]);
      check($sformatf("cfg%0d pending", c),  o_pend[c],  m_pend[c]);
      check($sformatf("cfg%0d any_tick", c), o_any[c],   m_any[c]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    #1;
    model_zero();
    compare_all();
  endtask

  typedef struct {
    logic [3:0] lvl;
    logic [3:0] clr;
    logic [3:0] tick;
    logic [3:0] rise;
    logic [3:0] state;
    logic [3:0] pend;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int second;
    logic seen;
    logic st_at_first;

    // Channel 0 in mode 11 (both edges), others rising-only, on config A.
    tbl[0] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2] = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1};
    tbl[3] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
    tbl[4] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
    tbl[5] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1};
    tbl[6] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    reset_n = 1'b0;
    level   = '0;
    mode    = 8'h57;
    clr     = '0;
    model_zero();
    #1;
    compare_all();
    step();
    step();
    reset_n = 1'b1;

    for (int r = 0; r < 8; r++) begin
      level = tbl[r].lvl;
      clr   = tbl[r].clr;
      step();
      check($sformatf("tbl%0d tick", r),    o_tick[0],  tbl[r].tick);
      check($sformatf("tbl%0d rise", r),    o_rise[0],  tbl[r].rise);
      check($sformatf("tbl%0d state", r),   o_state[0], tbl[r].state);
      check($sformatf("tbl%0d pending", r), o_pend[0],  tbl[r].pend);
      check($sformatf("tbl%0d any", r),     o_any[0],   |tbl[r].tick);
    end
    clr = '0;
    repeat (6) step();

    // Debounce: 3-cycle glitch is rejected.
    seen = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      level = (n <= 3) ? 4'h1 : 4'h0;
      step();
      seen |= o_tick[1][0];
    end
    check("deb glitch tick", seen, 1'b0);
    check("deb glitch state", o_state[1][0], 1'b0);

    // Debounce: 4-cycle pulse commits at k+5, drop commits 5 edges later.
    first = 0; second = 0; st_at_first = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      level = (n <= 4) ? 4'h1 : 4'h0;
      step();
      if (o_tick[1][0] && first == 0) begin
        first = n;
        st_at_first = o_state[1][0];
      end else if (o_tick[1][0] && second == 0) begin
        second = n;
      end
    end
    check("deb rise edge", first, 6);
    check("deb rise state", st_at_first, 1'b1);
    check("deb fall edge", second, 10);

    // Reset with all levels high: every channel commits rising after release.
    mode = 8'h55;
    level = 4'hF;
    assert_reset();
    step();
    step();
    reset_n = 1'b1;
    step();
    check("rstF A tick e1", o_tick[0], 4'h0);
    check("rstF C tick e1", o_tick[2], 4'hF);
    step();
    check("rstF A tick e2", o_tick[0], 4'h0);
    step();
    check("rstF A tick e3", o_tick[0], 4'hF);
    check("rstF A rise e3", o_rise[0], 4'hF);
    check("rstF A any e3", o_any[0], 1'b1);
    step();
    check("rstF A tick e4", o_tick[0], 4'h0);
    repeat (6) step();

    // Reset in the middle of a debounce filter discards the partial count.
    level = 4'h0;
    repeat (10) step();
    level = 4'h1;
    repeat (4) step();
    assert_reset();
    check("midrst B state", o_state[1], 4'h0);
    step();
    step();
    reset_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (o_tick[1][0] && first == 0) first = n;
    end
    check("midrst B tick edge", first, 6);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) mode = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) level[i] = ~level[i];
      end
      clr = '0;
      for (int i = 0; i < 4; i++) clr[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 599) == 0) begin
        assert_reset();
        step();
        reset_n = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
